// File: rtl/hazard_controller.sv
// hazard_controller
//   Stall, flush and forwarding control for a 5-stage MIPS pipeline. It also
//   tracks a multi-cycle mul/div unit and keeps a saturating count of stalled
//   cycles for performance measurement.
//
//   Handshake: there is no valid/ready pair. Every control output is a pure
//   combinational function of the current pipeline-register contents plus the
//   mul/div busy state. The pipeline consumes StallF/StallD/FlushE in the same
//   cycle they are produced.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   RsD, RtD            sources of the instruction in decode
//   RsE, RtE            sources of the instruction in execute
//   WriteReg{E,M,W}     destinations in E/M/W
//   RegWrite{E,M,W}     register-write enables in E/M/W
//   MemtoReg{E,M}       load flags in E/M
//   BranchD             branch in decode (compare resolved in ID)
//   MulDivD, MfhiloD    MULT/DIV or MFHI/MFLO in decode
//   MulDivE             MULT/DIV in execute (issue event)
//   StatClr             synchronous clear of StallCount
//   StallF, StallD      hold PC and IF/ID
//   FlushE              bubble into ID/EX
//   ForwardAE/BE        ALU operand select: 00 regfile, 10 from M, 01 from W
//   ForwardAD/BD        branch comparator operand from M
//   MdBusy              mul/div counter non-zero
//   StallCount          saturating count of stalled cycles
//   md_state_o          debug view of the mul/div FSM (1 = BUSY)

module hazard_controller #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             MulDivD,
  input  logic             MfhiloD,
  input  logic             MulDivE,
  input  logic             StatClr,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCount,
  output logic             md_state_o
);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [3:0]       MD_RELOAD = 4'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  md_state_e        state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lwstall;
  logic branchstall;
  logic mdstall;
  logic stall;

  // ---------------------------------------------------------------------------
  // Forwarding. M has priority over W because it holds the younger result.
  // Register 0 is hard-wired to zero and is never forwarded.
  // ---------------------------------------------------------------------------
  always_comb begin
    ForwardAE = 2'b00;
    if (RsE != 5'd0 && RegWriteM && WriteRegM == RsE)      ForwardAE = 2'b10;
    else if (RsE != 5'd0 && RegWriteW && WriteRegW == RsE) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RtE != 5'd0 && RegWriteM && WriteRegM == RtE)      ForwardBE = 2'b10;
    else if (RtE != 5'd0 && RegWriteW && WriteRegW == RtE) ForwardBE = 2'b01;

    ForwardAD = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
    ForwardBD = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);
  end

  // ---------------------------------------------------------------------------
  // Hazard detection. A branch compares in ID, so it must wait for an ALU
  // result still in E, or for load data still in M (not yet forwardable).
  // ---------------------------------------------------------------------------
  always_comb begin
    lwstall     = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
    branchstall = BranchD &&
                  ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                   (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    mdstall     = (MfhiloD || MulDivD) && (MulDivE || MdBusy);
    stall       = lwstall || branchstall || mdstall;
    StallF      = stall;
    StallD      = stall;
    FlushE      = stall;
  end

  // ---------------------------------------------------------------------------
  // Mul/div busy counter. An issue in E always reloads, so the last issue wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (MulDivE)               md_cnt_d = MD_RELOAD;
    else if (md_cnt_q != 4'd0) md_cnt_d = md_cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) md_cnt_q <= 4'd0;
    else        md_cnt_q <= md_cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Mul/div FSM: state register / next-state / outputs.
  // With MD_LATENCY=1 the counter never leaves 0, so the FSM stays IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (MulDivE && (MD_LATENCY > 1)) state_d = MD_BUSY;
      MD_BUSY: if (md_cnt_d == 4'd0)            state_d = MD_IDLE;
      default:                                  state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    MdBusy     = (md_cnt_q != 4'd0);
    md_state_o = (state_q == MD_BUSY);
  end

  // ---------------------------------------------------------------------------
  // Stall-cycle counter: clear beats increment, and it sticks at all-ones.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StatClr)                            stall_cnt_d = '0;
    else if (stall && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller with a narrow (4-bit) stall counter so that
// saturation is reachable quickly. A cycle-based reference model computes the
// expected outputs from the pipeline rules; a monitor compares on negedge.

module tb_hazard_controller;

  localparam int MD_LATENCY = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAXV   = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic BranchD, MulDivD, MfhiloD, MulDivE, StatClr;
  logic StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy, md_state_o;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCount;

  hazard_controller #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .MulDivD(MulDivD), .MfhiloD(MfhiloD),
    .MulDivE(MulDivE), .StatClr(StatClr),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MdBusy(MdBusy), .StallCount(StallCount), .md_state_o(md_state_o)
  );

  // ---------------- scoreboard state ----------------
  // Packed layout: {StallF,StallD,FlushE,ForwardAE,ForwardBE,ForwardAD,ForwardBD,MdBusy,StallCount}
  localparam int W = 10 + CNT_W;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: cycle index, first cycle in which the mul/div
  // unit is free again, and the raw number of stalled cycles since clear.
  int cyc     = 0;
  int md_free = 0;
  int n_stall = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {StallF, StallD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           MdBusy, StallCount};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %0h expected %0h", t, cyc, a, e);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] fwd_e(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (RegWriteM && WriteRegM == src) return 2'b10;
    if (RegWriteW && WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic fwd_d(input logic [4:0] src);
    return (src != 0) && RegWriteM && (WriteRegM == src);
  endfunction

  function automatic logic model_stall();
    logic lw, br, md, busy;
    busy = (cyc < md_free);
    lw = MemtoRegE && (RtE == RsD || RtE == RtD);
    br = BranchD && ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                     (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
    md = (MfhiloD || MulDivD) && (MulDivE || busy);
    return lw || br || md;
  endfunction

  // One clock cycle: push the expected outputs for the current inputs, then
  // advance the model on the edge.
  task automatic step(input string tag);
    logic s;
    logic [CNT_W-1:0] cnt;
    s   = model_stall();
    cnt = CNT_W'((n_stall > CNT_MAXV) ? CNT_MAXV : n_stall);
    exp_q.push_back({s, s, s, fwd_e(RsE), fwd_e(RtE), fwd_d(RsD), fwd_d(RtD),
                     (cyc < md_free), cnt});
    tag_q.push_back(tag);
    @(posedge clk);
    if (StatClr)  n_stall = 0;
    else if (s)   n_stall++;
    if (MulDivE)  md_free = cyc + MD_LATENCY;
    cyc++;
    #1;
  endtask

  task automatic zero_inputs();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
    {BranchD, MulDivD, MfhiloD, MulDivE, StatClr} = '0;
  endtask

  task automatic model_reset();
    n_stall = 0;
    md_free = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    zero_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", {15'd0, StallF}, 16'd0);
    check("reset_mdbusy", {15'd0, MdBusy}, 16'd0);
    check("reset_count", 16'(StallCount), 16'd0);
    check("reset_fwd", {10'd0, ForwardAE, ForwardBE, ForwardAD, ForwardBD}, 16'd0);
    rst_n = 1'b1;
    step("idle");

    // ALU forwarding priority and register 0
    RsE = 5; RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5; #1;
    check("fwd_ae_m", 16'(ForwardAE), 16'h2);
    step("fwd_m");
    RegWriteM = 0; #1;
    check("fwd_ae_w", 16'(ForwardAE), 16'h1);
    step("fwd_w");
    RsE = 0; RegWriteM = 1; #1;
    check("fwd_ae_r0", 16'(ForwardAE), 16'h0);
    step("fwd_r0");

    // Load-use: one stall cycle, counter 0 -> 1
    zero_inputs(); StatClr = 1; step("clr");
    StatClr = 0;
    MemtoRegE = 1; RtE = 8; RsD = 8; #1;
    check("lu_stall", {13'd0, StallF, StallD, FlushE}, 16'h7);
    step("lu");
    MemtoRegE = 0; #1;
    check("lu_release", {13'd0, StallF, StallD, FlushE}, 16'h0);
    check("lu_count", 16'(StallCount), 16'd1);
    step("lu_after");

    // Branch hazards
    zero_inputs(); BranchD = 1; RegWriteE = 1; WriteRegE = 3; RtD = 3; RsD = 7; #1;
    check("br_alu_e", {15'd0, StallF}, 16'd1);
    step("br_e");
    zero_inputs(); BranchD = 1; MemtoRegM = 1; WriteRegM = 4; RsD = 4; #1;
    check("br_load_m", {15'd0, StallF}, 16'd1);
    step("br_m_load");
    MemtoRegM = 0; RegWriteM = 1; #1;
    check("br_fwd_ad", {14'd0, StallF, ForwardAD}, 16'd1);
    step("br_m_fwd");

    // Mul/div: MULT in E at t, MFHI held in D
    zero_inputs(); MfhiloD = 1; MulDivE = 1;
    step("md_t");
    MulDivE = 0;
    for (int i = 1; i <= 5; i++) step("md_tail");
    check("md_idle", {15'd0, MdBusy}, 16'd0);

    // Reset asserted while the unit is busy (t+2)
    MulDivE = 1; step("md2_t");
    MulDivE = 0; step("md2_t1");
    #1;
    check("pre_rst_busy", {15'd0, MdBusy}, 16'd1);
    rst_n = 1'b0; #1;
    check("rst_async_busy", {15'd0, MdBusy}, 16'd0);
    check("rst_async_cnt", 16'(StallCount), 16'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("after_rst");

    // Saturation and clear-with-stall priority
    zero_inputs(); MemtoRegE = 1; RtE = 1; RsD = 1;
    for (int i = 0; i < 20; i++) step("sat");
    check("sat_hold", 16'(StallCount), 16'(CNT_MAXV));
    StatClr = 1; step("clr_pri");
    StatClr = 0; #1;
    check("clr_zero", 16'(StallCount), 16'd0);
    step("after_clr");

    // Randomized traffic over a small register set to make hazards common
    for (int i = 0; i < 2000; i++) begin
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = ($urandom_range(0, 3) == 0);
      MemtoRegM = ($urandom_range(0, 3) == 0);
      BranchD   = ($urandom_range(0, 3) == 0);
      MulDivD   = ($urandom_range(0, 5) == 0);
      MfhiloD   = ($urandom_range(0, 5) == 0);
      MulDivE   = ($urandom_range(0, 7) == 0);
      StatClr   = ($urandom_range(0, 40) == 0);
      step("rand");
    end

    zero_inputs();
    @(negedge clk); #1;
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Hazard and scheduling controller for the 5-stage MIPS pipeline. It produces the stall, flush and forwarding controls that sequence the IF/ID and ID/EX pipeline registers and the EX/ID bypass muxes. It also tracks a multi-cycle multiply/divide unit with a busy counter, holding back dependent HI/LO reads and back-to-back mul/div issues. A saturating stall-cycle counter is kept for performance measurement.

## Interface
- MD_LATENCY, 4: cycles the mul/div unit is busy after issue; legal range 1..15.
- CNT_W, 16: width of the stall-cycle counter.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- RsD, RtD  in  5 each  source registers of the instruction in decode
- RsE, RtE  in  5 each  source registers of the instruction in execute
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination registers in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enables in E/M/W
- MemtoRegE, MemtoRegM  in  1 each  load flags in E/M
- BranchD  in  1  decode holds a branch (compare done in ID)
- MulDivD  in  1  decode holds MULT/DIV
- MfhiloD  in  1  decode holds MFHI/MFLO
- MulDivE  in  1  execute holds MULT/DIV (issue event)
- StatClr  in  1  synchronous clear of StallCount
- StallF, StallD  out  1  hold PC and IF/ID
- FlushE  out  1  bubble into ID/EX
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 regfile, 10 from M, 01 from W
- ForwardAD, ForwardBD  out  1 each  branch comparator operand from M
- MdBusy  out  1  mul/div counter non-zero
- StallCount  out  CNT_W  saturating count of stalled cycles

## Operation
- Forwarding is combinational:
  - ForwardAE=10 if RsE!=0 and RegWriteM and WriteRegM==RsE.
  - Otherwise ForwardAE=01 if RsE!=0 and RegWriteW and WriteRegW==RsE.
  - Otherwise ForwardAE=00.
  - ForwardBE follows the same rules using RtE.
  - ForwardAD = RsD!=0 and RegWriteM and WriteRegM==RsD.
  - ForwardBD follows the same rule using RtD.
- Hazard terms:
  - lwstall = MemtoRegE and (RtE==RsD or RtE==RtD).
  - branchstall = BranchD and ((RegWriteE and WriteRegE in {RsD,RtD}) or (MemtoRegM and WriteRegM in {RsD,RtD})).
  - mdstall = (MfhiloD or MulDivD) and (MulDivE or MdBusy).
- Stall outputs: stall = lwstall | branchstall | mdstall. StallF = StallD = FlushE = stall.
- Mul/div counter (4-bit md_cnt):
  - MulDivE=1 loads MD_LATENCY-1.
  - Otherwise md_cnt decrements when non-zero.
  - MdBusy = (md_cnt!=0).
- State machine:
  - IDLE (md_cnt==0) goes to BUSY on MulDivE when MD_LATENCY>1.
  - BUSY goes to IDLE when md_cnt reaches 0.
  - MulDivE while BUSY reloads the counter; the last issue wins.
- StallCount:
  - Increments each cycle stall=1.
  - Saturates at all-ones.
  - StatClr has priority over the increment and forces 0.
- Boundary cases:
  - Register 0 is never forwarded and never causes forwarding.
  - Concurrent hazards OR together; no additional cycles are added.
  - Reset mid-operation clears md_cnt and StallCount immediately.

## Timing
- Forward*, Stall*, FlushE: combinational, same cycle as the inputs; no registered latency.
- md_cnt, StallCount: update on posedge clk.
- Reset values: md_cnt=0, MdBusy=0, StallCount=0. With all inputs 0, every combinational output is 0.
- A MULT in E at cycle t with MFHI in D:
  - stall is asserted in cycles t..t+MD_LATENCY-1.
  - MFHI enters E at t+MD_LATENCY+1.
  - Total stalled cycles = MD_LATENCY.
- MD_LATENCY=1: stall only during the MulDivE cycle; the counter never leaves 0.
- A load-use stall lasts one cycle. It clears automatically once the bubble moves the load to M (MemtoRegE=0).

## Test plan
- ALU forwarding from M:
  - Stimulus: RsE=5, RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5.
  - Required: ForwardAE=10.
  - Then drop RegWriteM: ForwardAE=01.
  - With RsE=0 and the same writes: ForwardAE=00.
- Load-use:
  - Stimulus: MemtoRegE=1, RtE=8, RsD=8 for one cycle.
  - Required: StallF=StallD=FlushE=1 and StallCount 0→1.
  - Next cycle MemtoRegE=0: all three deassert.
- Branch hazard:
  - BranchD=1, RegWriteE=1, WriteRegE=RtD=3 → stall=1.
  - Alternatively BranchD=1, MemtoRegM=1, WriteRegM=RsD=4 → stall=1.
  - RegWriteM=1 (MemtoRegM=0), WriteRegM=RsD → no stall, ForwardAD=1.
- Mul/div with MD_LATENCY=4:
  - Stimulus: MulDivE=1 at cycle t, MfhiloD held at 1.
  - Required: stall=1 for cycles t..t+3, MdBusy=1 for t+1..t+3, stall=0 at t+4.
  - StallCount advances by 4.
- Reset mid-busy:
  - Stimulus: assert rst_n=0 asynchronously at t+2 of the previous scenario.
  - Required: MdBusy=0 and StallCount=0 immediately, with no clock edge.
- Saturation and clear:
  - Run with CNT_W=4 and stall held for 20 cycles → StallCount=15 and holds there.
  - StatClr=1 together with stall=1 → 0 on the next edge.
